// File: rtl/vga_timing.sv
// vga_timing -- VGA raster timing generator on a single pixel clock.
//
// Purpose: walks a horizontal counter (hc) and a vertical counter (vc) over
// the frame raster, decodes the sync pulses and the visible window, counts
// completed frames and optionally raises a sticky vertical-blank interrupt.
//
// Optional feature: define VGA_TIMING_IRQ_EN to build the vblank interrupt
// logic (vblank_irq / irq_overrun). Without it both outputs are tied to 0
// and irq_ack is ignored; all ports stay present.
//
// Ports:
//   clk25        in   pixel clock, the only clock
//   clr          in   synchronous active-high reset, beats en and irq_ack
//   en           in   counting enable; counters hold and vidon=0 when low
//   irq_ack      in   vblank interrupt acknowledge
//   hc, vc       out  10-bit horizontal / vertical counters
//   vidon        out  visible-area flag (combinational)
//   hsync, vsync out  raw active-low syncs, decoded from hc / vc
//   hsync_d,
//   vsync_d      out  syncs delayed one clock to line up with a registered
//                     pixel stage downstream
//   frame_start  out  high while at the frame origin with en=1
//   vblank_irq   out  sticky interrupt, set one clock after the start of
//                     bottom blanking (hc=0, vc=VFP, en=1)
//   irq_overrun  out  sticky flag: interrupt event while one was pending
//   frame_cnt    out  16-bit completed-frame counter, wraps
module vga_timing #(
  parameter int HPIXELS = 800,
  parameter int VLINES  = 521,
  parameter int HSP     = 96,
  parameter int VSP     = 2,
  parameter int HBP     = 144,
  parameter int HFP     = 784,
  parameter int VBP     = 31,
  parameter int VFP     = 511
) (
  input  logic        clk25,
  input  logic        clr,
  input  logic        en,
  input  logic        irq_ack,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic        vidon,
  output logic        hsync,
  output logic        vsync,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        frame_start,
  output logic        vblank_irq,
  output logic        irq_overrun,
  output logic [15:0] frame_cnt
);

  // All compares are done at the counter width.
  localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST = 10'(VLINES - 1);
  localparam logic [9:0] HSP_C  = 10'(HSP);
  localparam logic [9:0] VSP_C  = 10'(VSP);
  localparam logic [9:0] HBP_C  = 10'(HBP);
  localparam logic [9:0] HFP_C  = 10'(HFP);
  localparam logic [9:0] VBP_C  = 10'(VBP);
  localparam logic [9:0] VFP_C  = 10'(VFP);

  logic h_last;
  logic v_last;

  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  // Combinational decodes of the counter registers.
  assign hsync       = (hc >= HSP_C);
  assign vsync       = (vc >= VSP_C);
  assign vidon       = en && (hc >= HBP_C) && (hc < HFP_C) &&
                       (vc >= VBP_C) && (vc < VFP_C);
  assign frame_start = en && (hc == 10'd0) && (vc == 10'd0);

  always_ff @(posedge clk25) begin
    if (clr) begin
      hc        <= 10'd0;
      vc        <= 10'd0;
      frame_cnt <= 16'd0;
      hsync_d   <= 1'b1;
      vsync_d   <= 1'b1;
    end else begin
      // The delayed syncs track every clock, independent of en.
      hsync_d <= hsync;
      vsync_d <= vsync;
      if (en) begin
        if (h_last) begin
          hc <= 10'd0;
          if (v_last) begin
            vc        <= 10'd0;
            frame_cnt <= frame_cnt + 16'd1;
          end else begin
            vc <= vc + 10'd1;
          end
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

`ifdef VGA_TIMING_IRQ_EN
  logic irq_event;

  // Start of bottom blanking; lasts one clock because hc moves on.
  assign irq_event = en && (hc == 10'd0) && (vc == VFP_C);

  always_ff @(posedge clk25) begin
    if (clr) begin
      vblank_irq  <= 1'b0;
      irq_overrun <= 1'b0;
    end else if (irq_event) begin
      // A new event wins over a coinciding acknowledge; the ack still
      // clears the overrun because software has just serviced the old one.
      vblank_irq <= 1'b1;
      if (irq_ack) begin
        irq_overrun <= 1'b0;
      end else if (vblank_irq) begin
        irq_overrun <= 1'b1;
      end
    end else if (irq_ack) begin
      vblank_irq  <= 1'b0;
      irq_overrun <= 1'b0;
    end
  end
`else
  logic irq_ack_unused;

  assign irq_ack_unused = irq_ack;
  assign vblank_irq     = 1'b0;
  assign irq_overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing -- self-checking bench for vga_timing.
//
// Uses a shrunken raster so whole frames fit in a short run. The reference
// model keeps the raster position as a single linear pixel index and derives
// every expected output from it arithmetically.
module tb_vga_timing;

  localparam int H     = 20;
  localparam int V     = 12;
  localparam int HSP   = 3;
  localparam int VSP   = 2;
  localparam int HBP   = 5;
  localparam int HFP   = 17;
  localparam int VBP   = 3;
  localparam int VFP   = 10;
  localparam int FRAME = H * V;

  // ---------------- clock / reset ----------------
  logic        clk25 = 1'b0;
  logic        clr   = 1'b1;
  logic        en    = 1'b0;
  logic        irq_ack = 1'b0;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        vidon;
  logic        hsync;
  logic        vsync;
  logic        hsync_d;
  logic        vsync_d;
  logic        frame_start;
  logic        vblank_irq;
  logic        irq_overrun;
  logic [15:0] frame_cnt;

  always #5 clk25 = ~clk25;

  vga_timing #(
    .HPIXELS(H), .VLINES(V), .HSP(HSP), .VSP(VSP),
    .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP)
  ) dut (
    .clk25(clk25), .clr(clr), .en(en), .irq_ack(irq_ack),
    .hc(hc), .vc(vc), .vidon(vidon), .hsync(hsync), .vsync(vsync),
    .hsync_d(hsync_d), .vsync_d(vsync_d), .frame_start(frame_start),
    .vblank_irq(vblank_irq), .irq_overrun(irq_overrun),
    .frame_cnt(frame_cnt)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;

  int pos;            // linear raster index vc*H + hc
  int frames;         // completed frames, mod 2^16
  bit m_irq;
  bit m_ovr;
  logic [1:0] exp_q[$];  // {hsync,vsync} history; front = previous clock

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos    = 0;
    frames = 0;
    m_irq  = 1'b0;
    m_ovr  = 1'b0;
    exp_q.delete();
    exp_q.push_back(2'b11);
  endtask

  function automatic bit e_hs();
    return (pos % H) >= HSP;
  endfunction

  function automatic bit e_vs();
    return (pos / H) >= VSP;
  endfunction

  task automatic check_outputs();
    int eh;
    int ev;
    bit ev_on;
    logic [1:0] dly;
    eh = pos % H;
    ev = pos / H;
    ev_on = en && eh >= HBP && eh < HFP && ev >= VBP && ev < VFP;
    dly = exp_q[0];
    check("hc", 32'(hc), 32'(eh));
    check("vc", 32'(vc), 32'(ev));
    check("hsync", 32'(hsync), 32'(e_hs()));
    check("vsync", 32'(vsync), 32'(e_vs()));
    check("vidon", 32'(vidon), 32'(ev_on));
    check("frame_start", 32'(frame_start), 32'(en && pos == 0));
    check("hsync_d", 32'(hsync_d), 32'(dly[1]));
    check("vsync_d", 32'(vsync_d), 32'(dly[0]));
    check("frame_cnt", 32'(frame_cnt), 32'(frames));
    check("vblank_irq", 32'(vblank_irq), 32'(m_irq));
    check("irq_overrun", 32'(irq_overrun), 32'(m_ovr));
  endtask

  // Advance the model by one clock edge using the inputs that were sampled.
  task automatic model_update(input logic c, input logic e, input logic a);
    bit ev_irq;
    logic [1:0] cur;
    if (c) begin
      model_reset();
      return;
    end
    cur = {e_hs(), e_vs()};
    exp_q.push_back(cur);
    while (exp_q.size() > 1) void'(exp_q.pop_front());
`ifdef VGA_TIMING_IRQ_EN
    ev_irq = e && (pos == VFP * H);
    if (ev_irq) begin
      if (a) m_ovr = 1'b0;
      else if (m_irq) m_ovr = 1'b1;
      m_irq = 1'b1;
    end else if (a) begin
      m_irq = 1'b0;
      m_ovr = 1'b0;
    end
`else
    ev_irq = 1'b0;
`endif
    if (e) begin
      if (pos == FRAME - 1) frames = (frames + 1) % 65536;
      pos = (pos + 1) % FRAME;
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, check, take the rising edge.
  task automatic step(input logic c, input logic e, input logic a);
    clr = c;
    en = e;
    irq_ack = a;
    #1;
    check_outputs();
    @(posedge clk25);
    model_update(c, e, a);
    @(negedge clk25);
  endtask

  // Run enabled until the model reaches the target position (bounded).
  task automatic goto_pos(input int target);
    int n;
    n = 0;
    while (pos != target && n < 2 * FRAME) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    check("goto_pos_reached", 32'(pos), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs_low;
    int vs_low;

    model_reset();
    repeat (2) @(posedge clk25);
    @(negedge clk25);

    // Reset state with clr held (en high must not matter).
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 0);

    // First frame from release: frame_start on the first clock, sync widths.
    hs_low = 0;
    vs_low = 0;
    for (int i = 0; i < FRAME; i++) begin
      clr = 1'b0; en = 1'b1; irq_ack = 1'b0;
      #1;
      if (i == 0) check("frame_start_first", 32'(frame_start), 32'd1);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      @(negedge clk25);
      clr = 1'b0;
      // Re-align: the loop above consumed a cycle without the model; redo
      // it through the driver instead.
      break;
    end
    // The probe above took one full clock with en=1 from the origin.
    model_update(1'b0, 1'b1, 1'b0);
    for (int i = 1; i < FRAME; i++) begin
      clr = 1'b0; en = 1'b1; irq_ack = 1'b0;
      #1;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      check_outputs();
      @(posedge clk25);
      model_update(1'b0, 1'b1, 1'b0);
      @(negedge clk25);
    end
    check("hsync_low_clocks", 32'(hs_low), 32'(V * HSP));
    check("vsync_low_clocks", 32'(vs_low), 32'(VSP * H));
    check("frame_cnt_one", 32'(frame_cnt), 32'd1);

    // Second unacknowledged frame: the interrupt goes pending then overruns.
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 1'b0);
    #1;
`ifdef VGA_TIMING_IRQ_EN
    check("irq_pending", 32'(vblank_irq), 32'd1);
    check("irq_overrun_set", 32'(irq_overrun), 32'd1);
`else
    check("irq_tied", 32'(vblank_irq), 32'd0);
    check("ovr_tied", 32'(irq_overrun), 32'd0);
`endif
    step(1'b0, 1'b1, 1'b1);
    #1;
    check("irq_after_ack", 32'(vblank_irq), 32'd0);
    check("ovr_after_ack", 32'(irq_overrun), 32'd0);

    // Event coinciding with ack: set wins, overrun cleared.
    goto_pos(VFP * H - 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    #1;
`ifdef VGA_TIMING_IRQ_EN
    check("irq_set_wins", 32'(vblank_irq), 32'd1);
`else
    check("irq_set_tied", 32'(vblank_irq), 32'd0);
`endif
    check("ovr_set_wins", 32'(irq_overrun), 32'd0);

    // Randomized traffic: gaps in en, random acks, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 19) == 0);
    end

    // Hold en low at hc=10 for 50 clocks.
    goto_pos(4 * H + 10);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, $urandom_range(0, 1));
    #1;
    check("hold_hc", 32'(hc), 32'd10);
    check("hold_vidon", 32'(vidon), 32'd0);

    // Mid-frame reset at hc=15, vc=7.
    goto_pos(7 * H + 15);
    step(1'b1, 1'b1, 1'b0);
    #1;
    check("rst_hc", 32'(hc), 32'd0);
    check("rst_vc", 32'(vc), 32'd0);
    check("rst_irq", 32'(vblank_irq), 32'd0);
    check("rst_hsync_d", 32'(hsync_d), 32'd1);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    for (int i = 0; i < FRAME + 20; i++) step(1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter HPIXELS, default 800: pixel clocks per line.
REQ-002 Parameter VLINES, default 521: lines per frame.
REQ-003 Parameter HSP, default 96: hsync pulse width in clocks.
REQ-004 Parameter VSP, default 2: vsync pulse width in lines.
REQ-005 Parameter HBP, default 144 / HFP, default 784: first / one-past-last visible hc.
REQ-006 Parameter VBP, default 31 / VFP, default 511: first / one-past-last visible vc.
REQ-007 clk25  in  1: pixel clock, the only clock.
REQ-008 clr  in  1: reset, synchronous, active-high.
REQ-009 en  in  1: counting enable.
REQ-010 irq_ack  in  1: vblank interrupt acknowledge.
REQ-011 hc  out  10: horizontal counter.
REQ-012 vc  out  10: vertical counter.
REQ-013 vidon  out  1: visible-area flag.
REQ-014 hsync / vsync  out  1 each: raw active-low syncs, aligned with hc/vc.
REQ-015 hsync_d / vsync_d  out  1 each: syncs delayed 1 clock, aligned with the registered pixel byte of the downstream pixel stage.
REQ-016 frame_start  out  1: one-clock pulse at frame origin.
REQ-017 vblank_irq  out  1: sticky vertical-blank interrupt.
REQ-018 irq_overrun  out  1: sticky flag for an interrupt raised while vblank_irq is already pending.
REQ-019 frame_cnt  out  16: completed-frame counter.

Function
REQ-020 hc SHALL count 0..HPIXELS-1 when en=1 and wrap to 0.
REQ-021 vc SHALL increment only on a clock where hc=HPIXELS-1, and wrap from VLINES-1 to 0.
REQ-022 With en=0, hc, vc and frame_cnt SHALL hold, and vidon SHALL be 0.
REQ-023 hsync SHALL be 0 iff hc<HSP; vsync SHALL be 0 iff vc<VSP; both are combinational decodes of the counter registers.
REQ-024 vidon SHALL be 1 iff HBP<=hc<HFP and VBP<=vc<VFP and en=1.
REQ-025 hsync_d / vsync_d SHALL equal hsync / vsync of the previous clock.
REQ-026 frame_start SHALL be 1 iff hc=0, vc=0 and en=1; it therefore asserts on the first enabled clock after reset.
REQ-027 frame_cnt SHALL increment by 1 on the clock where hc=HPIXELS-1 and vc=VLINES-1, and wrap from 65535 to 0.
REQ-028 Interrupt event: hc=0 and vc=VFP and en=1 (start of bottom blanking); vblank_irq goes 1 on the following clock.
REQ-029 When irq_ack=1 is sampled, vblank_irq and irq_overrun SHALL clear on the following clock.
REQ-030 If the event and irq_ack coincide, the set SHALL win: vblank_irq=1, and irq_overrun SHALL clear.
REQ-031 If the event occurs while vblank_irq=1 and irq_ack=0, irq_overrun SHALL be set.
REQ-032 All arithmetic SHALL use 10-bit counters, with compare constants truncated to 10 bits; no other outputs are registered.

Reset
REQ-033 On clr=1 at a clock edge: hc=0, vc=0, frame_cnt=0, vblank_irq=0, irq_overrun=0, hsync_d=1, vsync_d=1.
REQ-034 clr SHALL take priority over en and irq_ack.
REQ-035 Reset mid-frame SHALL restart at the frame origin with no spurious interrupt.

Configuration
REQ-036 Macro VGA_TIMING_IRQ_EN defined: REQ-028..031 logic is present.
REQ-037 Macro absent: vblank_irq and irq_overrun are tied 0, irq_ack is ignored, and the ports remain present.

Verification
REQ-038 Release clr with en=1 -> frame_start=1 on the first clock; hc reaches 799 then 0; vc becomes 1 on the same edge that hc wraps.
REQ-039 Run one full frame of 416800 clocks -> frame_cnt=1; hsync low for 96 clocks per line; vsync low for 1600 clocks.
REQ-040 Sample hc=144,vc=31 -> vidon=1; hc=784,vc=31 -> vidon=0; hc=200,vc=511 -> vidon=0.
REQ-041 With IRQ enabled, reach vc=511,hc=0 -> vblank_irq=1 next clock; leave it unacked for a frame -> irq_overrun=1; pulse irq_ack -> both clear.
REQ-042 Hold en=0 at hc=300 for 50 clocks -> hc stays 300 and vidon=0; assert clr at hc=400,vc=200 -> hc=0, vc=0, vblank_irq=0, hsync_d=1.
